// File: rtl/chacha_pkg.sv
// chacha_pkg: shared ChaCha block constants, state-matrix type and serialiser FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chacha_pkg;

    localparam int CHACHA_WORD_SIZE   = 32;
    localparam int CHACHA_NUM_WORDS   = 16;
    localparam int CHACHA_BLOCK_BYTES = 64;

    // One ChaCha20 output state, word 0 first.
    typedef logic [CHACHA_WORD_SIZE-1:0] chacha_matrix_t [0:CHACHA_NUM_WORDS-1];

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_e;

endpackage

// File: rtl/chacha_byte_select.sv
// chacha_byte_select: picks one output byte from a state matrix, little-endian within each word.
// Latency: purely combinational.
// Backpressure: none; the caller holds the index stable while stalled.
module chacha_byte_select #(
    parameter int WORD_SIZE = 32,
    parameter int DATA_SIZE = 8,
    parameter int NUM_WORDS = 16,
    parameter int IDX_W     = 6
)(
    input  logic [WORD_SIZE-1:0] i_matrix [0:NUM_WORDS-1],
    input  logic [IDX_W-1:0]     i_idx,
    output logic [DATA_SIZE-1:0] o_byte
);

    // Lanes per word must be a power of two so the index splits cleanly into word/lane fields.
    localparam int LANES  = WORD_SIZE / DATA_SIZE;
    localparam int LANE_W = $clog2(LANES);

    logic [IDX_W-LANE_W-1:0]           w_word;
    logic [LANE_W-1:0]                 w_lane;
    logic [LANES-1:0][DATA_SIZE-1:0]   w_lanes;

    assign w_word  = i_idx[IDX_W-1:LANE_W];
    assign w_lane  = i_idx[LANE_W-1:0];
    assign w_lanes = i_matrix[w_word];

    // Lane 0 is the least significant byte of the word, so it goes out first.
    always_comb begin
        o_byte = w_lanes[w_lane];
    end

endmodule

// File: rtl/chacha_block_serialiser.sv
// chacha_block_serialiser: captures a 16x32 ChaCha state and streams it as 64 little-endian bytes.
// Latency: byte 0 valid the cycle after acceptance; one byte per cycle while data_ready is high.
// Backpressure: data_out/data_last held while stalled; CHACHA_SERIALISER_DOUBLE_BUF_EN adds a pending buffer for gapless blocks.
module chacha_block_serialiser
    import chacha_pkg::*;
#(
    parameter int WORD_SIZE = CHACHA_WORD_SIZE,
    parameter int DATA_SIZE = 8,
    parameter int NUM_WORDS = CHACHA_NUM_WORDS
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] matrix_in [0:NUM_WORDS-1],
    input  logic                 matrix_valid,
    output logic                 matrix_ready,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 data_last,
    output logic [15:0]          block_count
);

    localparam int BLOCK_BYTES = NUM_WORDS * (WORD_SIZE / DATA_SIZE);
    localparam int IDX_W       = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(BLOCK_BYTES - 2);

    ser_state_e           r_state;
    logic [IDX_W-1:0]     r_byte_idx;
    logic [WORD_SIZE-1:0] r_active [0:NUM_WORDS-1];
    logic                 r_data_valid;
    logic                 r_data_last;
    logic [15:0]          r_block_count;

`ifdef CHACHA_SERIALISER_DOUBLE_BUF_EN
    logic [WORD_SIZE-1:0] r_pending [0:NUM_WORDS-1];
    logic                 r_pending_full;
`endif

    logic w_accept;
    logic w_xfer;

    // Ready depends only on registered state so data_ready never reaches matrix_ready.
`ifdef CHACHA_SERIALISER_DOUBLE_BUF_EN
    assign matrix_ready = !r_pending_full;
`else
    assign matrix_ready = (r_state == IDLE);
`endif

    assign w_accept    = matrix_valid && matrix_ready;
    assign w_xfer      = r_data_valid && data_ready;
    assign data_valid  = r_data_valid;
    assign data_last   = r_data_last;
    assign block_count = r_block_count;

    chacha_byte_select #(
        .WORD_SIZE (WORD_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_byte_select (
        .i_matrix (r_active),
        .i_idx    (r_byte_idx),
        .o_byte   (data_out)
    );

    // Serialiser FSM: capture a matrix, walk the byte index on each transfer, count finished blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_byte_idx    <= '0;
            r_data_valid  <= 1'b0;
            r_data_last   <= 1'b0;
            r_block_count <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_active[i] <= '0;
            end
`ifdef CHACHA_SERIALISER_DOUBLE_BUF_EN
            r_pending_full <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_pending[i] <= '0;
            end
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifdef CHACHA_SERIALISER_DOUBLE_BUF_EN
                    // A matrix parked on the final-byte edge is promoted before new input is taken.
                    if (r_pending_full) begin
                        r_active       <= r_pending;
                        r_pending_full <= 1'b0;
                        r_state        <= STREAM;
                        r_byte_idx     <= '0;
                        r_data_valid   <= 1'b1;
                        r_data_last    <= 1'b0;
                    end else if (w_accept) begin
`else
                    if (w_accept) begin
`endif
                        r_active     <= matrix_in;
                        r_state      <= STREAM;
                        r_byte_idx   <= '0;
                        r_data_valid <= 1'b1;
                        r_data_last  <= 1'b0;
                    end
                end

                STREAM: begin
`ifdef CHACHA_SERIALISER_DOUBLE_BUF_EN
                    // Matrices arriving mid-block wait in the pending buffer.
                    if (w_accept) begin
                        r_pending      <= matrix_in;
                        r_pending_full <= 1'b1;
                    end
`endif
                    if (w_xfer) begin
                        if (r_byte_idx == LAST_IDX) begin
                            r_block_count <= r_block_count + 16'd1;
                            r_byte_idx    <= '0;
                            r_data_last   <= 1'b0;
`ifdef CHACHA_SERIALISER_DOUBLE_BUF_EN
                            if (r_pending_full) begin
                                r_active       <= r_pending;
                                r_pending_full <= 1'b0;
                            end else
`endif
                            begin
                                r_state      <= IDLE;
                                r_data_valid <= 1'b0;
                            end
                        end else begin
                            r_byte_idx  <= r_byte_idx + 1'b1;
                            r_data_last <= (r_byte_idx == PENULT_IDX);
                        end
                    end
                end

                default: begin
                    r_state      <= IDLE;
                    r_data_valid <= 1'b0;
                    r_data_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_serialiser.sv
// tb_chacha_block_serialiser: randomized bench comparing the byte stream against a queue-based model.
// Latency: n/a.
// Backpressure: drives data_ready with fixed and random stall patterns.
module tb_chacha_block_serialiser;

    typedef chacha_pkg::chacha_matrix_t mat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    mat_t        matrix_in;
    logic        matrix_valid = 1'b0;
    logic        matrix_ready;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        data_last;
    logic [15:0] block_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          last_q[$];
    logic [15:0] exp_count;
    mat_t        seq_m;

    always #5 clk = ~clk;

    chacha_block_serialiser dut (
        .clk          (clk),
        .rst          (rst),
        .matrix_in    (matrix_in),
        .matrix_valid (matrix_valid),
        .matrix_ready (matrix_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_last    (data_last),
        .block_count  (block_count)
    );

    // Reference: a block is its 16 words, each emitted low byte first.
    task automatic append_expected(input mat_t m);
        logic [31:0] t;
        for (int w = 0; w < 16; w++) begin
            for (int l = 0; l < 4; l++) begin
                t = m[w] >> (8 * l);
                exp_q.push_back(t[7:0]);
            end
        end
    endtask

    function automatic int q_diff();
        int d = 0;
        if (got_q.size() != exp_q.size()) d++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) d++;
        end
        return d;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < 16; i++) m[i] = $urandom();
        return m;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic offer(input mat_t m, output bit ok);
        matrix_in    = m;
        matrix_valid = 1'b1;
        ok           = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (matrix_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        matrix_valid = 1'b0;
    endtask

    // Records n transferred bytes; mode 0 ready=1, mode 1 ready 1,0,0,1..., else random.
    task automatic collect(input int n, input int mode, output int unstable, output int gaps, output bit timeout);
        logic [8:0] prev;
        bit have_prev;
        bit started;
        bit rdy;
        got_q.delete();
        last_q.delete();
        unstable  = 0;
        gaps      = 0;
        started   = 1'b0;
        have_prev = 1'b0;
        prev      = '0;
        for (int c = 0; c < n * 4 + 100 && got_q.size() < n; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((c % 4) == 0) || ((c % 4) == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            data_ready = rdy;
            if (have_prev && (!data_valid || {data_last, data_out} !== prev)) unstable++;
            have_prev = 1'b0;
            if (data_valid) begin
                started = 1'b1;
                if (rdy) begin
                    got_q.push_back(data_out);
                    if (data_last) last_q.push_back(got_q.size() - 1);
                end else begin
                    have_prev = 1'b1;
                    prev      = {data_last, data_out};
                end
            end else if (started) begin
                gaps++;
            end
            @(negedge clk);
        end
        timeout = (got_q.size() < n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_out); end
        n_cmp++; if (data_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", data_last); end
        n_cmp++; if (block_count !== 16'h0000) begin n_bad++; $display("FAIL reset_count: got %h want 0000", block_count); end
        rst = 1'b0;
        exp_count = 16'h0000;
        @(negedge clk);
        n_cmp++; if (matrix_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", matrix_ready); end
    endtask

    task automatic test_in_order();
        bit ok; int unst; int gaps; bit to;
        for (int k = 0; k < 16; k++) begin
            seq_m[k] = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
        end
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
        data_ready = 1'b0;
        offer(seq_m, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL order_accept: got timeout want accept"); end
        n_cmp++; if (data_valid !== 1'b1 || data_out !== 8'h00) begin n_bad++; $display("FAIL order_latency: got v=%b d=%h want v=1 d=00", data_valid, data_out); end
        collect(64, 0, unst, gaps, to);
        exp_count = exp_count + 16'd1;
        n_cmp++; if (to || q_diff() != 0) begin n_bad++; $display("FAIL order_bytes: got %0d bytes %0d diffs want 64 bytes 0 diffs", got_q.size(), q_diff()); end
        n_cmp++; if (last_q.size() != 1 || last_q[0] != 63) begin n_bad++; $display("FAIL order_last: got %0d marks want 1 mark at 63", last_q.size()); end
        n_cmp++; if (block_count !== exp_count) begin n_bad++; $display("FAIL order_count: got %h want %h", block_count, exp_count); end
        n_cmp++; if (matrix_ready !== 1'b1 || data_valid !== 1'b0) begin n_bad++; $display("FAIL order_idle: got rdy=%b v=%b want rdy=1 v=0", matrix_ready, data_valid); end
    endtask

    task automatic test_stall();
        bit ok; int unst; int gaps; bit to;
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
        data_ready = 1'b0;
        offer(seq_m, ok);
        collect(64, 1, unst, gaps, to);
        exp_count = exp_count + 16'd1;
        n_cmp++; if (!ok || to || q_diff() != 0) begin n_bad++; $display("FAIL stall_bytes: got %0d bytes %0d diffs want 64 bytes 0 diffs", got_q.size(), q_diff()); end
        n_cmp++; if (unst != 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", unst); end
        n_cmp++; if (last_q.size() != 1 || last_q[0] != 63) begin n_bad++; $display("FAIL stall_last: got %0d marks want 1 mark at 63", last_q.size()); end
        n_cmp++; if (block_count !== exp_count) begin n_bad++; $display("FAIL stall_count: got %h want %h", block_count, exp_count); end
    endtask

    task automatic test_random();
        bit ok; int unst; int gaps; bit to; mat_t m;
        for (int r = 0; r < 3; r++) begin
            m = rand_mat();
            exp_q.delete();
            append_expected(m);
            data_ready = 1'b0;
            offer(m, ok);
            collect(64, 2, unst, gaps, to);
            exp_count = exp_count + 16'd1;
            n_cmp++; if (!ok || to || q_diff() != 0) begin n_bad++; $display("FAIL rand_bytes[%0d]: got %0d diffs want 0", r, q_diff()); end
            n_cmp++; if (unst != 0) begin n_bad++; $display("FAIL rand_stable[%0d]: got %0d changes want 0", r, unst); end
            n_cmp++; if (block_count !== exp_count) begin n_bad++; $display("FAIL rand_count[%0d]: got %h want %h", r, block_count, exp_count); end
        end
    endtask

`ifdef CHACHA_SERIALISER_DOUBLE_BUF_EN
    task automatic test_back_to_back();
        bit ok1; bit ok2; bit to; int unst; int gaps; logic pend_rdy; mat_t m1; mat_t m2;
        m1 = rand_mat();
        for (int i = 0; i < 16; i++) m2[i] = m1[i] ^ 32'hFFFFFFFF;
        exp_q.delete();
        append_expected(m1);
        append_expected(m2);
        pend_rdy = 1'b1;
        fork
            begin
                offer(m1, ok1);
                offer(m2, ok2);
                pend_rdy = matrix_ready;
            end
            collect(128, 0, unst, gaps, to);
        join
        exp_count = exp_count + 16'd2;
        n_cmp++; if (!ok1 || !ok2) begin n_bad++; $display("FAIL b2b_accept: got %b%b want 11", ok1, ok2); end
        n_cmp++; if (pend_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_pending_ready: got %b want 0", pend_rdy); end
        n_cmp++; if (to || gaps != 0) begin n_bad++; $display("FAIL b2b_gaps: got %0d bubbles want 0", gaps); end
        n_cmp++; if (q_diff() != 0) begin n_bad++; $display("FAIL b2b_bytes: got %0d diffs want 0", q_diff()); end
        n_cmp++; if (last_q.size() != 2 || last_q[0] != 63 || last_q[1] != 127) begin n_bad++; $display("FAIL b2b_last: got %0d marks want 63,127", last_q.size()); end
        n_cmp++; if (block_count !== exp_count) begin n_bad++; $display("FAIL b2b_count: got %h want %h", block_count, exp_count); end
    endtask
`else
    task automatic test_back_to_back();
        bit vq[$]; bit rq[$]; int accepted; int first_v; int last_v; int nv; int bubbles; int readies; mat_t m1; mat_t m2;
        m1 = rand_mat();
        m2 = rand_mat();
        exp_q.delete();
        append_expected(m1);
        append_expected(m2);
        got_q.delete();
        last_q.delete();
        matrix_in    = m1;
        matrix_valid = 1'b1;
        data_ready   = 1'b1;
        accepted     = 0;
        for (int c = 0; c < 140; c++) begin
            vq.push_back(data_valid);
            rq.push_back(matrix_ready);
            if (data_valid) begin
                got_q.push_back(data_out);
                if (data_last) last_q.push_back(got_q.size() - 1);
            end
            if (matrix_ready && matrix_valid) accepted++;
            if (accepted >= 1 && !matrix_ready) matrix_in = m2;
            if (accepted == 2 && !matrix_ready) matrix_valid = 1'b0;
            @(negedge clk);
        end
        matrix_valid = 1'b0;
        exp_count = exp_count + 16'd2;
        first_v = -1; last_v = -1; nv = 0;
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i]) begin
                if (first_v < 0) first_v = i;
                nv++;
                if (nv == 128) last_v = i;
            end
        end
        bubbles = 0; readies = 0;
        if (first_v >= 0 && last_v >= 0) begin
            for (int i = first_v; i <= last_v; i++) begin
                if (!vq[i]) bubbles++;
                if (rq[i]) readies++;
            end
        end
        n_cmp++; if (q_diff() != 0) begin n_bad++; $display("FAIL b2b_bytes: got %0d bytes %0d diffs want 128 bytes 0 diffs", got_q.size(), q_diff()); end
        n_cmp++; if (last_v < 0 || bubbles != 1) begin n_bad++; $display("FAIL b2b_bubble: got %0d idle cycles want 1", bubbles); end
        n_cmp++; if (last_v < 0 || readies != 1) begin n_bad++; $display("FAIL b2b_ready: got %0d ready cycles want 1", readies); end
        n_cmp++; if (last_q.size() != 2 || last_q[0] != 63 || last_q[1] != 127) begin n_bad++; $display("FAIL b2b_last: got %0d marks want 63,127", last_q.size()); end
        n_cmp++; if (block_count !== exp_count) begin n_bad++; $display("FAIL b2b_count: got %h want %h", block_count, exp_count); end
    endtask
`endif

    task automatic test_reset_mid();
        bit ok; int unst; int gaps; bit to; mat_t m;
        m = rand_mat();
        data_ready = 1'b0;
        offer(m, ok);
        collect(20, 0, unst, gaps, to);
        data_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_count = 16'h0000;
        n_cmp++; if (data_valid !== 1'b0 || data_out !== 8'h00) begin n_bad++; $display("FAIL midrst_out: got v=%b d=%h want v=0 d=00", data_valid, data_out); end
        n_cmp++; if (block_count !== exp_count) begin n_bad++; $display("FAIL midrst_count: got %h want 0000", block_count); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m = rand_mat();
        exp_q.delete();
        append_expected(m);
        offer(m, ok);
        collect(64, 0, unst, gaps, to);
        exp_count = exp_count + 16'd1;
        n_cmp++; if (!ok || to || q_diff() != 0) begin n_bad++; $display("FAIL midrst_restart: got %0d diffs want 0", q_diff()); end
        n_cmp++; if (block_count !== exp_count) begin n_bad++; $display("FAIL midrst_count2: got %h want %h", block_count, exp_count); end
    endtask

    task automatic test_wrap();
        bit ok; int unst; int gaps; bit to; mat_t m;
        force dut.r_block_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_block_count;
        @(negedge clk);
        exp_count = 16'hFFFE;
        n_cmp++; if (block_count !== exp_count) begin n_bad++; $display("FAIL wrap_preset: got %h want %h", block_count, exp_count); end
        for (int b = 0; b < 2; b++) begin
            m = rand_mat();
            data_ready = 1'b0;
            offer(m, ok);
            collect(64, 0, unst, gaps, to);
            exp_count = exp_count + 16'd1;
            n_cmp++; if (!ok || to || block_count !== exp_count) begin n_bad++; $display("FAIL wrap_count[%0d]: got %h want %h", b, block_count, exp_count); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) matrix_in[i] = '0;
        exp_count = 16'h0000;
        #1;
        test_reset();
        test_in_order();
        test_stall();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
